// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder for the core's
// unified instruction/data port. One request is accepted at a time over a
// valid/ready handshake. It is serviced from a local word array after a fixed
// LATENCY, and completion is signalled with a one-cycle rsp_valid pulse.
// Array commit and read-data capture both happen at the edge that enters RESP.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // The WAIT counter starts at LATENCY-2. With LATENCY == 1 the WAIT state is
  // never entered, so the load value is pinned to zero.
  localparam logic [3:0] LP_CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  // Reject illegal parameterisations at elaboration.
  if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end
  if ((DEPTH_LOG2 < 1) || (DEPTH_LOG2 > 30)) begin : g_bad_depth
    $error("mem_responder: DEPTH_LOG2 must be in 1..30");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State, counter, and latched request
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;

  logic                    r_we;
  logic [3:0]              r_be;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [1:0]              r_lo;
  logic [31:0]             r_wdata;

  // Registered outputs and their next-cycle values
  logic                    r_req_ready;
  logic                    r_busy;
  logic                    r_rsp_valid;
  logic [31:0]             r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    w_ready_nxt;
  logic                    w_busy_nxt;
  logic                    w_valid_nxt;

  // Data path signals
  logic                    w_accept;
  logic                    w_commit;
  logic                    w_sel_we;
  logic [3:0]              w_sel_be;
  logic [DEPTH_LOG2-1:0]   w_sel_idx;
  logic [1:0]              w_sel_lo;
  logic [31:0]             w_sel_wdata;
  logic                    w_aligned;
  logic                    w_mem_we;

  logic [31:0]             r_mem [DEPTH];

  // Upper address bits are deliberately ignored, so the array wraps.
  logic                    w_unused_addr;
  assign w_unused_addr = ^req_addr[31:DEPTH_LOG2+2];

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // Commit happens on the edge that moves the FSM into RESP.
  assign w_commit = (w_state_nxt == S_RESP) && (r_state != S_RESP);

  // State register and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LP_CNT_LOAD;
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        // No backpressure: the response pulse is always one cycle long.
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so that the outputs can be registered.
  always_comb begin
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
      S_WAIT: begin
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        w_valid_nxt = 1'b0;
      end
      S_RESP: begin
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        w_valid_nxt = 1'b1;
      end
      default: begin
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Capture the request on accept; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_idx   <= '0;
      r_lo    <= 2'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_be    <= req_be;
      r_idx   <= req_addr[DEPTH_LOG2+1:2];
      r_lo    <= req_addr[1:0];
      r_wdata <= req_wdata;
    end else begin
      r_we    <= r_we;
    end
  end

  // Select the operation to commit. With LATENCY == 1, RESP is entered
  // directly from IDLE, so the commit uses the request being accepted.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_sel_we    = req_we;
      w_sel_be    = req_be;
      w_sel_idx   = req_addr[DEPTH_LOG2+1:2];
      w_sel_lo    = req_addr[1:0];
      w_sel_wdata = req_wdata;
    end else begin
      w_sel_we    = r_we;
      w_sel_be    = r_be;
      w_sel_idx   = r_idx;
      w_sel_lo    = r_lo;
      w_sel_wdata = r_wdata;
    end
  end

  assign w_aligned = (w_sel_lo == 2'b00);
  assign w_mem_we  = w_commit && w_sel_we && w_aligned;

  // Byte-lane array write. Contents are kept through reset, but a commit
  // never lands while reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Contents are retained; only the pending commit is suppressed.
    end else if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_sel_be[i]) begin
          r_mem[w_sel_idx][8*i +: 8] <= w_sel_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered handshake and response outputs. Read data and error flag are
  // updated only at the commit edge and hold their values otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_valid_nxt;
      if (w_commit) begin
        r_rsp_err <= ~w_aligned;
        if (!w_sel_we && w_aligned) begin
          r_rsp_rdata <= r_mem[w_sel_idx];
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
